// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants,
// common to the receive path and the transmitter's tick logic.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      DONE  = 3'd4
   } rx_state_t;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 8;

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one-clk s_tick every tick_div clocks, re-phasable via clr.
module baud_tick_gen #(
   parameter int tick_div = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic s_tick
);

   localparam int CW = (tick_div > 1) ? $clog2(tick_div) : 1;

   logic [CW-1:0] cnt_reg;

   assign s_tick = (cnt_reg == CW'(tick_div - 1));

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt_reg <= '0;
      end else if (s_tick) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 16x oversampled, mid-cell sampling, MSB-first data,
// one-cycle rx_done strobe with a framing-error flag.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int nbits    = 8,
   parameter int stpbits  = 2,
   parameter int tick_div = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx,
   output logic [nbits-1:0] rx_dout,
   output logic             rx_done,
   output logic             frame_err,
   output logic             rx_busy
);

   localparam int NMAX = (nbits > stpbits) ? nbits : stpbits;
   localparam int NW   = $clog2(NMAX) + 1;

   rx_state_t        state_reg, state_next;
   logic [3:0]       s_cnt_reg, s_cnt_next;
   logic [NW-1:0]    n_cnt_reg, n_cnt_next;
   logic [nbits-1:0] shreg_reg, shreg_next;
   logic             err_reg, err_next;
   logic [nbits-1:0] dout_reg, dout_next;
   logic             ferr_reg, ferr_next;
   logic             rx_meta_reg, rxs_reg, rxs_prev_reg;
   logic             s_tick;
   logic             tick_clr;

   baud_tick_gen #(.tick_div(tick_div)) u_tick (
      .clk    (clk),
      .reset  (reset),
      .clr    (tick_clr),
      .s_tick (s_tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         s_cnt_reg    <= '0;
         n_cnt_reg    <= '0;
         shreg_reg    <= '0;
         err_reg      <= 1'b0;
         dout_reg     <= '0;
         ferr_reg     <= 1'b0;
         rx_meta_reg  <= 1'b1;
         rxs_reg      <= 1'b1;
         rxs_prev_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         s_cnt_reg    <= s_cnt_next;
         n_cnt_reg    <= n_cnt_next;
         shreg_reg    <= shreg_next;
         err_reg      <= err_next;
         dout_reg     <= dout_next;
         ferr_reg     <= ferr_next;
         rx_meta_reg  <= rx;
         rxs_reg      <= rx_meta_reg;
         rxs_prev_reg <= rxs_reg;
      end
   end

   always_comb begin
      state_next = state_reg;
      s_cnt_next = s_cnt_reg;
      n_cnt_next = n_cnt_reg;
      shreg_next = shreg_reg;
      err_next   = err_reg;
      dout_next  = dout_reg;
      ferr_next  = ferr_reg;
      tick_clr   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (rxs_prev_reg && !rxs_reg) begin
               state_next = START;
               s_cnt_next = '0;
               tick_clr   = 1'b1;
            end
         end
         START: begin
            if (s_tick) begin
               if (s_cnt_reg == 4'(MID_SAMPLE - 1)) begin
                  if (rxs_reg) begin
                     state_next = IDLE;
                  end else begin
                     state_next = DATA;
                     s_cnt_next = '0;
                     n_cnt_next = '0;
                     err_next   = 1'b0;
                  end
               end else begin
                  s_cnt_next = s_cnt_reg + 1'b1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_cnt_reg == 4'(OVERSAMPLE - 1)) begin
                  s_cnt_next = '0;
                  shreg_next = {shreg_reg[nbits-2:0], rxs_reg};
                  if (n_cnt_reg == NW'(nbits - 1)) begin
                     n_cnt_next = '0;
                     state_next = STOP;
                  end else begin
                     n_cnt_next = n_cnt_reg + 1'b1;
                  end
               end else begin
                  s_cnt_next = s_cnt_reg + 1'b1;
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (s_cnt_reg == 4'(OVERSAMPLE - 1)) begin
                  s_cnt_next = '0;
                  err_next   = err_reg | ~rxs_reg;
                  if (n_cnt_reg == NW'(stpbits - 1)) begin
                     n_cnt_next = '0;
                     state_next = DONE;
                     // Load on DONE entry so the word and flag are valid alongside rx_done.
                     dout_next  = shreg_reg;
                     ferr_next  = err_next;
                  end else begin
                     n_cnt_next = n_cnt_reg + 1'b1;
                  end
               end else begin
                  s_cnt_next = s_cnt_reg + 1'b1;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign rx_dout   = dout_reg;
   assign frame_err = ferr_reg;
   assign rx_done   = (state_reg == DONE);
   assign rx_busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: per-scenario tasks driving the serial line at 160 clk/bit.
module tb_uart_receiver;

   localparam int BIT = 160;

   logic       clk;
   logic       reset;
   logic       rx;
   logic [7:0] rx_dout;
   logic       rx_done;
   logic       frame_err;
   logic       rx_busy;

   int n_checks;
   int n_fail;
   int done_count;
   int err_count;
   int consec_count;
   bit prev_done;
   logic [7:0] got_q[$];
   logic       got_err_q[$];

   uart_receiver #(.nbits(8), .stpbits(2), .tick_div(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .rx_dout   (rx_dout),
      .rx_done   (rx_done),
      .frame_err (frame_err),
      .rx_busy   (rx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Passive monitor: records every rx_done pulse with its word and error flag.
   always @(negedge clk) begin
      if (rx_done) begin
         done_count++;
         got_q.push_back(rx_dout);
         got_err_q.push_back(frame_err);
         if (frame_err) err_count++;
         if (prev_done) consec_count++;
      end
      prev_done = rx_done;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit bad_stop2);
      rx = 1'b0;
      wait_clk(BIT);
      for (int i = 7; i >= 0; i--) begin
         rx = d[i];
         wait_clk(BIT);
      end
      rx = 1'b1;
      wait_clk(BIT);
      rx = bad_stop2 ? 1'b0 : 1'b1;
      wait_clk(BIT);
      rx = 1'b1;
   endtask

   task automatic test_reset();
      rx    = 1'b1;
      reset = 1'b1;
      wait_clk(4);
      reset = 1'b0;
      wait_clk(2);
      n_checks++;
      if (rx_dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got=%h exp=00", rx_dout); end
      n_checks++;
      if (rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", rx_done); end
      n_checks++;
      if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
      n_checks++;
      if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
      wait_clk(50);
      $display("test_reset done");
   endtask

   task automatic test_single();
      int c0;
      logic busy_mid;
      c0 = done_count;
      got_q.delete();
      got_err_q.delete();
      fork
         send_frame(8'hA5, 1'b0);
         begin wait_clk(3 * BIT); busy_mid = rx_busy; end
      join
      wait_clk(20);
      n_checks++;
      if (busy_mid !== 1'b1) begin n_fail++; $display("FAIL single_busy_mid got=%b exp=1", busy_mid); end
      n_checks++;
      if (done_count - c0 !== 1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", done_count - c0); end
      n_checks++;
      if (rx_dout !== 8'hA5) begin n_fail++; $display("FAIL single_dout got=%h exp=a5", rx_dout); end
      n_checks++;
      if (frame_err !== 1'b0) begin n_fail++; $display("FAIL single_ferr got=%b exp=0", frame_err); end
      n_checks++;
      if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after got=%b exp=0", rx_busy); end
      $display("test_single frame a5 rx_dout=%h frame_err=%b", rx_dout, frame_err);
   endtask

   task automatic test_back_to_back();
      int c0;
      c0 = done_count;
      got_q.delete();
      send_frame(8'h00, 1'b0);
      send_frame(8'hFF, 1'b0);
      wait_clk(20);
      n_checks++;
      if (done_count - c0 !== 2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=2", done_count - c0); end
      if (got_q.size() == 2) begin
         n_checks++;
         if (got_q[0] !== 8'h00) begin n_fail++; $display("FAIL b2b_word0 got=%h exp=00", got_q[0]); end
         n_checks++;
         if (got_q[1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_word1 got=%h exp=ff", got_q[1]); end
      end
      n_checks++;
      if (rx_dout !== 8'hFF) begin n_fail++; $display("FAIL b2b_dout got=%h exp=ff", rx_dout); end
      $display("test_back_to_back frames 00,ff received=%0d", got_q.size());
   endtask

   task automatic test_glitch();
      int c0;
      logic busy_during;
      c0 = done_count;
      rx = 1'b0;
      wait_clk(40);
      rx = 1'b1;
      wait_clk(20);
      busy_during = rx_busy;
      wait_clk(300);
      n_checks++;
      if (busy_during !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start got=%b exp=1", busy_during); end
      n_checks++;
      if (done_count - c0 !== 0) begin n_fail++; $display("FAIL glitch_count got=%0d exp=0", done_count - c0); end
      n_checks++;
      if (rx_dout !== 8'hFF) begin n_fail++; $display("FAIL glitch_dout got=%h exp=ff", rx_dout); end
      n_checks++;
      if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy got=%b exp=0", rx_busy); end
      $display("test_glitch 40clk low pulse rx_busy=%b", rx_busy);
   endtask

   task automatic test_frame_err();
      send_frame(8'h3C, 1'b1);
      wait_clk(2 * BIT);
      n_checks++;
      if (rx_dout !== 8'h3C) begin n_fail++; $display("FAIL ferr_dout got=%h exp=3c", rx_dout); end
      n_checks++;
      if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_flag got=%b exp=1", frame_err); end
      $display("test_frame_err frame 3c bad stop rx_dout=%h frame_err=%b", rx_dout, frame_err);
      send_frame(8'h81, 1'b0);
      wait_clk(20);
      n_checks++;
      if (rx_dout !== 8'h81) begin n_fail++; $display("FAIL ferr_next_dout got=%h exp=81", rx_dout); end
      n_checks++;
      if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_next_flag got=%b exp=0", frame_err); end
      $display("test_frame_err frame 81 clean rx_dout=%h frame_err=%b", rx_dout, frame_err);
   endtask

   task automatic test_mid_reset();
      int c0;
      c0 = done_count;
      // 0x55 MSB first: 0,1,0,1,... ; reset lands mid fourth data bit
      rx = 1'b0; wait_clk(BIT);
      rx = 1'b0; wait_clk(BIT);
      rx = 1'b1; wait_clk(BIT);
      rx = 1'b0; wait_clk(BIT);
      rx = 1'b1; wait_clk(BIT / 2);
      reset = 1'b1;
      wait_clk(1);
      reset = 1'b0;
      wait_clk(1);
      n_checks++;
      if (rx_dout !== 8'h00) begin n_fail++; $display("FAIL midrst_dout got=%h exp=00", rx_dout); end
      n_checks++;
      if (frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_ferr got=%b exp=0", frame_err); end
      n_checks++;
      if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", rx_busy); end
      rx = 1'b1;
      wait_clk(12 * BIT);
      n_checks++;
      if (done_count - c0 !== 0) begin n_fail++; $display("FAIL midrst_count got=%0d exp=0", done_count - c0); end
      $display("test_mid_reset aborted 55 frame outputs=%h/%b", rx_dout, frame_err);
      send_frame(8'h55, 1'b0);
      wait_clk(20);
      n_checks++;
      if (done_count - c0 !== 1) begin n_fail++; $display("FAIL midrst_next_count got=%0d exp=1", done_count - c0); end
      n_checks++;
      if (rx_dout !== 8'h55) begin n_fail++; $display("FAIL midrst_next_dout got=%h exp=55", rx_dout); end
      $display("test_mid_reset frame 55 rx_dout=%h", rx_dout);
   endtask

   task automatic test_break();
      int c0;
      c0 = done_count;
      rx = 1'b0;
      wait_clk(20 * BIT);
      n_checks++;
      if (done_count - c0 !== 1) begin n_fail++; $display("FAIL break_count got=%0d exp=1", done_count - c0); end
      n_checks++;
      if (rx_dout !== 8'h00) begin n_fail++; $display("FAIL break_dout got=%h exp=00", rx_dout); end
      n_checks++;
      if (frame_err !== 1'b1) begin n_fail++; $display("FAIL break_ferr got=%b exp=1", frame_err); end
      n_checks++;
      if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL break_busy got=%b exp=0", rx_busy); end
      rx = 1'b1;
      wait_clk(4 * BIT);
      n_checks++;
      if (done_count - c0 !== 1) begin n_fail++; $display("FAIL break_release_count got=%0d exp=1", done_count - c0); end
      $display("test_break line low frame_err=%b", frame_err);
   endtask

   task automatic test_loopback();
      logic [7:0] exp_q[$];
      logic [7:0] b;
      int e0;
      e0 = err_count;
      got_q.delete();
      for (int i = 0; i < 16; i++) begin
         b = 8'($urandom_range(0, 255));
         exp_q.push_back(b);
         send_frame(b, 1'b0);
      end
      wait_clk(20);
      n_checks++;
      if (got_q.size() !== 16) begin n_fail++; $display("FAIL loop_count got=%0d exp=16", got_q.size()); end
      for (int i = 0; i < 16; i++) begin
         if (i < got_q.size()) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL loop_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end else begin
               $display("loopback byte %0d rx_dout=%h", i, got_q[i]);
            end
         end
      end
      n_checks++;
      if (err_count - e0 !== 0) begin n_fail++; $display("FAIL loop_ferr got=%0d exp=0", err_count - e0); end
   endtask

   task automatic test_done_pulse();
      n_checks++;
      if (consec_count !== 0) begin n_fail++; $display("FAIL done_consecutive got=%0d exp=0", consec_count); end
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      done_count   = 0;
      err_count    = 0;
      consec_count = 0;
      prev_done    = 1'b0;
      rx           = 1'b1;
      reset        = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_mid_reset();
      test_break();
      test_loopback();
      test_done_pulse();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage, the consumer of the transmitter's serial line.
- Frame format matches the transmitter: 1 start bit (low), nbits data bits sent MSB first, stpbits stop bits (high), idle high.
- Oversamples at 16 ticks per bit from an internal divided tick, samples each bit mid-cell, and presents the assembled word with a one-cycle done strobe and a framing-error flag.

Parameters:
- nbits, 8, data bits per frame.
- stpbits, 2, stop bits per frame.
- tick_div, 10, clk cycles per oversample tick; one bit = 16*tick_div clk.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- rx_dout  output  nbits  last received word, MSB = first data bit on the line.
- rx_done  output  1  one-cycle pulse, frame complete; rx_dout and frame_err valid from this cycle.
- frame_err  output  1  set with rx_done if any stop-bit sample was low; held until next rx_done.
- rx_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, active-high), effective on the next clk edge:
  - rx_dout=0, rx_done=0, frame_err=0, rx_busy=0.
  - State IDLE; tick, sample and bit counters 0.
  - Synchroniser flops set to 1; the edge-detect previous-sample register set to 0.
  - A reset mid-frame discards the partial word; no rx_done is issued.
- Synchroniser: 2-flop on rx. All decisions use the synchronised value rxs.
- Tick generator:
  - Free-running counter 0..tick_div-1.
  - s_tick=1 for one clk when the counter equals tick_div-1.
  - Counter cleared on reset and on start-edge detection, which re-phases the ticks to the frame.
- Start detection: a falling edge is rxs_prev=1 and rxs=0 while in IDLE.
  - A line held low out of reset therefore never starts a frame until it has first gone high.
- START state:
  - On the 8th s_tick after detection, sample rxs (mid start bit).
  - rxs=1 means a glitch: return to IDLE with no rx_done.
  - rxs=0: clear the sample counter and bit counter, go to DATA.
- DATA state:
  - Every 16th s_tick, sample rxs and shift it in: shreg <= {shreg[nbits-2:0], rxs}, giving MSB first.
  - After nbits samples, go to STOP.
- STOP state:
  - Every 16th s_tick, sample rxs. Any low sample sets the internal error bit.
  - After stpbits samples, go to DONE.
- DONE state, exactly one clk:
  - rx_done=1; rx_dout<=shreg; frame_err<=error bit.
  - Return to IDLE. A new start edge can be detected on the next clk.
- Latency: rx_done rises 2 clk (synchroniser) + 1 clk after the mid-cell sample of the last stop bit. That sample falls (8 + 16*(nbits+stpbits)) ticks after start detection.
- rx_done is never asserted in two consecutive cycles.
- rx_dout and frame_err change only in the DONE cycle or on reset.
- Break (line stuck low): the frame completes with frame_err=1. No further frame is accepted until rxs returns high.
- No overrun handling: a consumer that misses rx_done loses that word.

Decomposition:
- Shared package uart_pkg:
  - State enum IDLE/START/DATA/STOP/DONE.
  - Constants OVERSAMPLE=16 and MID_SAMPLE=8.
  - These are shared with the transmitter's tick logic.
- One natural sub-module: baud_tick_gen (parameter tick_div; ports clk, reset, clr, s_tick).
  - It is reused by the transmitter when that block is reworked.

Test Plan:
- Send 8'hA5, 2 stop bits, at 160 clk/bit -> one rx_done pulse; rx_dout=8'hA5; frame_err=0; rx_busy low after DONE.
- Back-to-back frames 8'h00 then 8'hFF with no idle gap beyond the stop bits -> two rx_done pulses; rx_dout=8'h00 then 8'hFF.
- 40-clk low glitch on an idle line -> return to IDLE after the mid-start sample; no rx_done; rx_dout unchanged.
- Frame 8'h3C with the second stop bit driven low -> rx_done with rx_dout=8'h3C and frame_err=1. The next clean frame 8'h81 -> frame_err=0.
- Assert reset for 1 clk midway through the data bits of 8'h55 -> no rx_done; all outputs 0. The following frame 8'h55 is received correctly.
- Loopback against the transmitter (same nbits/stpbits, tick_div=10), sending 16 random bytes -> every byte matches; frame_err never set.
